// File: rtl/vrom_arbiter.sv
// vrom_arbiter: two-port read arbiter in front of a synchronous VROM.
// Port 0 (video fetch) has fixed priority over port 1. Every accepted read
// returns its data exactly three cycles after the grant cycle, tagged through
// a two-stage pipeline that records which port owns the word.
// Optional feature: define VROM_ARB_STARVE_EN to compile in a wait counter
// that forces a port-1 grant after MAX_WAIT consecutive denied cycles.
module vrom_arbiter #(
  parameter int ROM_WIDTH     = 12,
  parameter int ROM_ADDR_BITS = 20,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic [ROM_ADDR_BITS-1:0] addr0,
  output logic                     gnt0,
  output logic                     valid0,
  output logic [ROM_WIDTH-1:0]     data0,
  input  logic                     req1,
  input  logic [ROM_ADDR_BITS-1:0] addr1,
  output logic                     gnt1,
  output logic                     valid1,
  output logic [ROM_WIDTH-1:0]     data1,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data
);

  // Tag pipeline: vld marks an accepted read, port is 1 when port 1 owns it.
  logic vld_p1;
  logic port_p1;
  logic vld_p2;
  logic port_p2;

`ifdef VROM_ARB_STARVE_EN
  logic [3:0] wait_cnt;
  logic       force1;

  assign force1 = req1 && (wait_cnt == 4'(MAX_WAIT));

  // Stage p0: grant decision, with a forced port-1 slot once it has waited long enough.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (force1) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Count consecutive cycles port 1 is requesting but denied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (req1 && !gnt1) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end
`else
  // Stage p0: plain fixed-priority grant, port 1 only when port 0 is idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end
`endif

  // Stage p1: drive the granted address to the ROM; hold it when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
    end else if (gnt0) begin
      rom_addr <= addr0;
    end else if (gnt1) begin
      rom_addr <= addr1;
    end
  end

  // Stages p1/p2 and output: shift the read tag alongside the ROM access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      port_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      port_p2 <= 1'b0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
    end else begin
      vld_p1  <= gnt0 || gnt1;
      port_p1 <= gnt1;
      vld_p2  <= vld_p1;
      port_p2 <= port_p1;
      valid0  <= vld_p2 && !port_p2;
      valid1  <= vld_p2 && port_p2;
    end
  end

  // Output stage: capture ROM data into the owning port; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
    end else if (vld_p2) begin
      if (port_p2) begin
        data1 <= rom_data;
      end else begin
        data0 <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_vrom_arbiter.sv
// Directed testbench for vrom_arbiter with a synchronous ROM model.
module tb_vrom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [19:0] addr0;
  logic        gnt0;
  logic        valid0;
  logic [11:0] data0;
  logic        req1;
  logic [19:0] addr1;
  logic        gnt1;
  logic        valid1;
  logic [11:0] data1;
  logic [19:0] rom_addr;
  logic [11:0] rom_data;

  int vectors;
  int miscompares;

  vrom_arbiter #(
    .ROM_WIDTH(12),
    .ROM_ADDR_BITS(20),
    .MAX_WAIT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0(req0),
    .addr0(addr0),
    .gnt0(gnt0),
    .valid0(valid0),
    .data0(data0),
    .req1(req1),
    .addr1(addr1),
    .gnt1(gnt1),
    .valid1(valid1),
    .data1(data1),
    .rom_addr(rom_addr),
    .rom_data(rom_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] rom_f(input logic [19:0] a);
    return a[11:0] + a[19:8] + 12'h5A5;
  endfunction

  // Synchronous ROM: data appears one cycle after the address.
  always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 20'h12345;
    req1 = 1'b1; addr1 = 20'h54321;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0: got %0h expected 0", gnt0); end
    vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt1: got %0h expected 0", gnt1); end
    vectors++; if ({valid0, valid1} !== 2'b00) begin miscompares++; $display("FAIL reset_valid: got %0h expected 0", {valid0, valid1}); end
    vectors++; if (data0 !== 12'h0) begin miscompares++; $display("FAIL reset_data0: got %0h expected 0", data0); end
    vectors++; if (data1 !== 12'h0) begin miscompares++; $display("FAIL reset_data1: got %0h expected 0", data1); end
    vectors++; if (rom_addr !== 20'h0) begin miscompares++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); end
    // Release; the first cycle after release must already grant port 0.
    next_cycle();
    rst_n = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL first_gnt0: got %0h expected 1", gnt0); end
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    vectors++; if (rom_addr !== 20'h12345) begin miscompares++; $display("FAIL first_rom_addr: got %0h expected 12345", rom_addr); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || data0 !== rom_f(20'h12345)) begin miscompares++; $display("FAIL first_read: got valid %0h data %0h expected valid 1 data %0h", valid0, data0, rom_f(20'h12345)); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_single();
    req0 = 1'b1; addr0 = 20'h00010;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL single_gnt: got %0h%0h expected 10", gnt0, gnt1); end
    next_cycle();
    req0 = 1'b0; addr0 = 20'h0BEEF;
    @(negedge clk);
    vectors++; if (rom_addr !== 20'h00010) begin miscompares++; $display("FAIL single_rom_addr: got %0h expected 10", rom_addr); end
    vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL single_early_valid_n1: got %0h expected 0", valid0); end
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL single_early_valid_n2: got %0h expected 0", valid0); end
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || valid1 !== 1'b0) begin miscompares++; $display("FAIL single_valid: got %0h%0h expected 10", valid0, valid1); end
    vectors++; if (data0 !== rom_f(20'h00010)) begin miscompares++; $display("FAIL single_data0: got %0h expected %0h", data0, rom_f(20'h00010)); end
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b0 || data0 !== rom_f(20'h00010)) begin miscompares++; $display("FAIL single_hold: got valid %0h data %0h expected 0 %0h", valid0, data0, rom_f(20'h00010)); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    req0 = 1'b1; addr0 = 20'h00A00;
    req1 = 1'b1; addr1 = 20'h3C0F0;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin miscompares++; $display("FAIL simul_gnt_n: got %0h%0h expected 10", gnt0, gnt1); end
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin miscompares++; $display("FAIL simul_gnt_n1: got %0h%0h expected 01", gnt0, gnt1); end
    next_cycle();
    req1 = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || valid1 !== 1'b0 || data0 !== rom_f(20'h00A00)) begin miscompares++; $display("FAIL simul_valid0: got %0h%0h data %0h expected 10 data %0h", valid0, valid1, data0, rom_f(20'h00A00)); end
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b0 || valid1 !== 1'b1 || data1 !== rom_f(20'h3C0F0)) begin miscompares++; $display("FAIL simul_valid1: got %0h%0h data %0h expected 01 data %0h", valid0, valid1, data1, rom_f(20'h3C0F0)); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      req0 = (i < 10);
      addr0 = 20'(i);
      @(negedge clk);
      if (i < 10) begin
        vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL stream_gnt0[%0d]: got %0h expected 1", i, gnt0); end
      end
      if (i >= 3 && i < 13) begin
        vectors++; if (valid0 !== 1'b1 || data0 !== rom_f(20'(i - 3))) begin miscompares++; $display("FAIL stream_read[%0d]: got valid %0h data %0h expected 1 %0h", i - 3, valid0, data0, rom_f(20'(i - 3))); end
      end else begin
        vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL stream_idle[%0d]: got %0h expected 0", i, valid0); end
      end
      next_cycle();
    end
    req0 = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp0;
    logic exp1;
    req0 = 1'b1; addr0 = 20'h00100;
    req1 = 1'b1; addr1 = 20'h00200;
    for (int i = 0; i < 10; i++) begin
`ifdef VROM_ARB_STARVE_EN
      exp1 = (i == 8);
`else
      exp1 = 1'b0;
`endif
      exp0 = !exp1;
      @(negedge clk);
      vectors++; if (gnt0 !== exp0 || gnt1 !== exp1) begin miscompares++; $display("FAIL starve_gnt[%0d]: got %0h%0h expected %0h%0h", i, gnt0, gnt1, exp0, exp1); end
      vectors++; if (valid0 === 1'b1 && valid1 === 1'b1) begin miscompares++; $display("FAIL starve_both_valid[%0d]: got 11 expected not both", i); end
      next_cycle();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (valid0 === 1'b1 && valid1 === 1'b1) begin miscompares++; $display("FAIL drain_both_valid[%0d]: got 11 expected not both", i); end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    req0 = 1'b1; addr0 = 20'h00ABC;
    @(negedge clk);
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL mid_gnt0: got %0h expected 1", gnt0); end
    next_cycle();
    req0 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if ({gnt0, gnt1, valid0, valid1} !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_ctrl: got %0h expected 0", {gnt0, gnt1, valid0, valid1}); end
    vectors++; if (rom_addr !== 20'h0 || data0 !== 12'h0 || data1 !== 12'h0) begin miscompares++; $display("FAIL mid_reset_data: got %0h %0h %0h expected 0 0 0", rom_addr, data0, data1); end
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (valid0 !== 1'b0 || valid1 !== 1'b0 || data0 !== 12'h0) begin miscompares++; $display("FAIL mid_ghost[%0d]: got valid %0h%0h data %0h expected 00 0", i, valid0, valid1, data0); end
      next_cycle();
    end
  endtask

  task automatic test_idle_hold();
    req0 = 1'b1; addr0 = 20'hFFFFF;
    next_cycle();
    req0 = 1'b0; addr0 = 20'h00000;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++; if (valid0 !== 1'b1 || data0 !== rom_f(20'hFFFFF)) begin miscompares++; $display("FAIL idle_read: got valid %0h data %0h expected 1 %0h", valid0, data0, rom_f(20'hFFFFF)); end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (rom_addr !== 20'hFFFFF) begin miscompares++; $display("FAIL idle_rom_addr[%0d]: got %0h expected fffff", i, rom_addr); end
      vectors++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin miscompares++; $display("FAIL idle_valid[%0d]: got %0h%0h expected 00", i, valid0, valid1); end
      vectors++; if (data0 !== rom_f(20'hFFFFF)) begin miscompares++; $display("FAIL idle_data0[%0d]: got %0h expected %0h", i, data0, rom_f(20'hFFFFF)); end
      next_cycle();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req0 = 1'b0; addr0 = '0;
    req1 = 1'b0; addr1 = '0;
    #1;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_reset_midflight();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
